axi_llc_way_arbiter: RTL



---
 rtl/axi_llc_way_arbiter_pkg.sv | 26 ++
 rtl/axi_llc_way_arbiter_if.sv | 35 +++
 rtl/axi_llc_way_arbiter_fifo.sv | 61 ++++++
 rtl/axi_llc_way_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/axi_llc_way_arbiter_pkg.sv
// Shared types and constants for the LLC data-way request arbiter.
package axi_llc_way_arbiter_pkg;

  // Number of cache units sharing the data-way port (write, read, evict, refill).
  localparam int unsigned NumUnits    = 4;
  // Outstanding read requests the route FIFO can track.
  localparam int unsigned MaxWayReads = 4;

  localparam int unsigned UnitIdxWidth = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  // Index of a requesting unit; this is what the route FIFO stores.
  typedef logic [UnitIdxWidth-1:0] way_unit_idx_t;

  // Request towards the data ways.
  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } way_inp_t;

  // Response from the data ways.
  typedef struct packed {
    logic [31:0] data;
  } way_oup_t;

endpackage

// File: rtl/axi_llc_way_arbiter_if.sv
// Bundles the unit request/response ports and the data-way port.
// The arbiter takes the slave view; units and data ways take the master view.
interface axi_llc_way_arbiter_if
  import axi_llc_way_arbiter_pkg::*;
#(
  parameter int unsigned NumUnits = axi_llc_way_arbiter_pkg::NumUnits
) ();

  way_inp_t [NumUnits-1:0] req;
  logic     [NumUnits-1:0] req_valid;
  logic     [NumUnits-1:0] req_ready;

  way_inp_t                way_inp;
  logic                    way_inp_valid;
  logic                    way_inp_ready;

  way_oup_t                way_oup;
  logic                    way_oup_valid;
  logic                    way_oup_ready;

  way_oup_t [NumUnits-1:0] rsp;
  logic     [NumUnits-1:0] rsp_valid;
  logic     [NumUnits-1:0] rsp_ready;

  modport slave (
    input  req, req_valid, way_inp_ready, way_oup, way_oup_valid, rsp_ready,
    output req_ready, way_inp, way_inp_valid, way_oup_ready, rsp, rsp_valid
  );

  modport master (
    output req, req_valid, way_inp_ready, way_oup, way_oup_valid, rsp_ready,
    input  req_ready, way_inp, way_inp_valid, way_oup_ready, rsp, rsp_valid
  );

endinterface

// File: rtl/axi_llc_way_arbiter_fifo.sv
// Non-fall-through route FIFO holding the requester index of each pending read.
// A push is accepted while full if a pop happens in the same cycle.
module axi_llc_way_arbiter_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             testmode_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                do_push, do_pop;

  // No clock gating inside this FIFO, so testmode has nothing to bypass.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (32'(ptr) == Depth - 1) ? '0 : ptr + PtrWidth'(1);
  endfunction

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntWidth'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntWidth'(1);
    end
  end

  // Entry storage.
  // NOTE: the storage array has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_llc_way_arbiter.sv
// Round-robin arbiter sharing the data-way request port between LLC units.
// A grant is held until the data ways accept it; read requesters are queued
// in order so each data-way response is steered back to its originator.
// NumUnits must be >= 2 and MaxReads >= 1.
module axi_llc_way_arbiter
  import axi_llc_way_arbiter_pkg::*;
#(
  parameter int unsigned NumUnits = axi_llc_way_arbiter_pkg::NumUnits,
  parameter int unsigned MaxReads = MaxWayReads
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  input logic                   test_i,
  axi_llc_way_arbiter_if.slave  bus
);

  localparam int unsigned IdxWidth = $clog2(NumUnits);
  typedef logic [IdxWidth-1:0] unit_idx_t;

  unit_idx_t           prio_q, sel_q, sel, head;
  logic                lock_q;
  logic                valid, handshake, push, pop;
  logic                fifo_full, fifo_empty;
  logic [NumUnits-1:0] eligible;

  // Reads need a free route slot; writes are never held back by the FIFO.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumUnits; i++) begin
      eligible[i] = bus.req_valid[i] && (bus.req[i].we || !fifo_full);
    end
  end

  // Circular search from prio_q, or replay the held grant while locked.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    sel   = prio_q;
    valid = 1'b0;
    if (lock_q) begin
      sel   = sel_q;
      valid = eligible[sel_q];
    end else begin
      for (int unsigned k = 0; k < NumUnits; k++) begin
        idx = (32'(prio_q) + k) % NumUnits;
        if (!valid && eligible[unit_idx_t'(idx)]) begin
          valid = 1'b1;
          sel   = unit_idx_t'(idx);
        end
      end
    end
  end

  assign handshake         = valid && bus.way_inp_ready;
  assign push              = handshake && !bus.req[sel].we;
  assign bus.way_inp_valid = valid;
  assign bus.way_inp       = bus.req[sel];

  // Only the selected unit sees the data-way ready.
  always_comb begin
    bus.req_ready      = '0;
    bus.req_ready[sel] = handshake;
  end

  // Priority rotation and grant lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
    end else if (handshake) begin
      lock_q <= 1'b0;
      prio_q <= (32'(sel) == NumUnits - 1) ? '0 : sel + unit_idx_t'(1);
    end else if (valid) begin
      lock_q <= 1'b1;
      sel_q  <= sel;
    end
  end

  axi_llc_way_arbiter_fifo #(
    .Depth (MaxReads),
    .Width (IdxWidth)
  ) i_route_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .testmode_i (test_i),
    .push_i     (push),
    .data_i     (sel),
    .pop_i      (pop),
    .data_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Steer the response valid to the unit at the route FIFO head.
  always_comb begin
    bus.rsp_valid       = '0;
    bus.rsp_valid[head] = bus.way_oup_valid && !fifo_empty;
  end

  // Response payload is broadcast; only the one-hot valid selects the receiver.
  always_comb begin
    for (int i = 0; i < NumUnits; i++) begin
      bus.rsp[i] = bus.way_oup;
    end
  end

  assign bus.way_oup_ready = bus.rsp_ready[head] && !fifo_empty;
  assign pop               = bus.way_oup_valid && bus.way_oup_ready;

  // A response with no pending read route is a data-way protocol error.
  rsp_without_route: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.way_oup_valid |-> !fifo_empty);

  rsp_valid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.rsp_valid));

endmodule
